div_unit: RTL and testbench

//  Multi-cycle DIV/DIVU sequencer for the EX stage; supplies the divide datapath the EX stage lacks.
//  - Accepts one divide request from EX and stalls the pipeline while it iterates one quotient bit per cycle.
//  - Writes {HI=remainder, LO=quotient} through the HI/LO write port.
//  - Aborts cleanly on pipeline flush (exception).

---
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, result written
// to HI/LO as {remainder, quotient}. Stalls EX while iterating; flush aborts without a write.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flag_unsigned,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic               we_hilo,
    output logic [2*WIDTH-1:0] hilo_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone, StDzero} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;

    logic               dvd_neg, dsr_neg;
    logic [WIDTH-1:0]   dvd_abs, dsr_abs;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   rem_step, quo_step;
    logic [WIDTH-1:0]   rem_fin, quo_fin;

    always_comb begin
        dvd_neg  = !flag_unsigned && dividend[WIDTH-1];
        dsr_neg  = !flag_unsigned && divisor[WIDTH-1];
        dvd_abs  = dvd_neg ? (~dividend + 1'b1) : dividend;
        dsr_abs  = dsr_neg ? (~divisor + 1'b1) : divisor;

        // Restoring step: trial subtract on WIDTH+1 bits, sign bit selects restore.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, div_q};
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_fin  = r_neg_q ? (~rem_step + 1'b1) : rem_step;
        quo_fin  = q_neg_q ? (~quo_step + 1'b1) : quo_step;

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        hilo_d   = hilo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_neg_d = dvd_neg ^ dsr_neg;
                    r_neg_d = dvd_neg;
                    quo_d   = dvd_abs;
                    div_d   = dsr_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (divisor != '0) begin
                        state_d = StCalc;
                    end else begin
                        state_d = StDzero;
                        hilo_d  = {dividend, {WIDTH{1'b1}}};
                    end
                end
            end
            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StDone;
                    hilo_d  = {rem_fin, quo_fin};
                end
            end
            StDone:  state_d = StIdle;
            StDzero: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including a result about to be presented.
        if (cancel) begin
            state_d = StIdle;
            hilo_d  = hilo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hilo_q  <= hilo_d;
        end
    end

    always_comb begin
        busy    = rst_n && ((state_q == StIdle && start && !cancel) || state_q == StCalc);
        done    = rst_n && !cancel && (state_q == StDone || state_q == StDzero);
        we_hilo = done;
        hilo_o  = hilo_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy window, signed/unsigned results, x/0,
// flush and mid-operation reset.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flag_unsigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        we_hilo;
    logic [63:0] hilo_o;

    int n_tests;
    int n_fail;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flag_unsigned(flag_unsigned),
        .dividend     (dividend),
        .divisor      (divisor),
        .cancel       (cancel),
        .busy         (busy),
        .done         (done),
        .we_hilo      (we_hilo),
        .hilo_o       (hilo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide at the next negedge (cycle 0) and follow it to its result.
    task automatic run_div(input string tag, input logic uns, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int exp_lat);
        int lat;
        int nbusy;
        @(negedge clk);
        flag_unsigned = uns;
        dividend      = a;
        divisor       = b;
        start         = 1'b1;
        #1;
        nbusy = busy ? 1 : 0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) nbusy++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " we_hilo"}, 64'(we_hilo), 64'd1);
        check({tag, " hilo"}, hilo_o, {exp_hi, exp_lo});
        @(negedge clk);
        #1;
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " we pulse"}, 64'(we_hilo), 64'd0);
    endtask

    initial begin
        int cnt;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        start         = 1'b1;
        cancel        = 1'b0;
        flag_unsigned = 1'b1;
        dividend      = 32'd7;
        divisor       = 32'd2;

        // Reset: start held high must not raise busy or produce a result.
        repeat (3) @(negedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset we_hilo", 64'(we_hilo), 64'd0);
        check("reset hilo", hilo_o, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle busy", 64'(busy), 64'd0);

        run_div("divu 7/2", 1'b1, 32'd7, 32'd2, 32'h1, 32'h3, 33);
        run_div("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_div("div 7/-2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33);
        run_div("divu ffffffff/10", 1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 33);
        run_div("div ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_div("div -8/-3", 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h2, 33);
        run_div("div 5/0", 1'b0, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF, 1);

        // Flush at CALC cycle 10: no write, back to idle, hilo holds the x/0 result.
        @(negedge clk);
        flag_unsigned = 1'b0;
        dividend      = 32'd100;
        divisor       = 32'd7;
        start         = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        cancel = 1'b1;
        #1;
        check("cancel cycle done", 64'(done), 64'd0);
        check("cancel cycle we", 64'(we_hilo), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("after cancel busy", 64'(busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (we_hilo || busy) cnt++;
        end
        check("after cancel quiet", 64'(cnt), 64'd0);
        check("after cancel hilo held", hilo_o, {32'h5, 32'hFFFF_FFFF});

        run_div("div 9/3", 1'b0, 32'd9, 32'd3, 32'h0, 32'h3, 33);

        // start together with cancel in IDLE is dropped.
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        cancel   = 1'b1;
        #1;
        check("start+cancel busy", 64'(busy), 64'd0);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        cnt    = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            #1;
            if (done || busy) cnt++;
        end
        check("start+cancel dropped", 64'(cnt), 64'd0);

        // Reset at cycle 20 of a divide.
        @(negedge clk);
        flag_unsigned = 1'b1;
        dividend      = 32'd1000;
        divisor       = 32'd3;
        start         = 1'b1;
        cnt           = 0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) cnt++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check("mid reset no early done", 64'(cnt), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset we", 64'(we_hilo), 64'd0);
        check("mid reset hilo", hilo_o, 64'd0);
        rst_n = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            #1;
            if (done || busy) cnt++;
        end
        check("post reset quiet", 64'(cnt), 64'd0);

        run_div("divu 1000/3", 1'b1, 32'd1000, 32'd3, 32'h1, 32'd333, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
